rf_access_responder: RTL and testbench

Register-file responder: the target end of the register access protocol that the instruction processor issues. Accepts one access request at a time, with up to two reads and one write, carried as a 3-bit access mask. Executes the phases sequentially on single-ported storage, then returns read data and a completion handshake. Sits between the instruction processor and the architectural register storage.

---
 rtl/rf_access_responder.sv | 133 +++++++++++++
 tb/tb_rf_access_responder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rf_access_responder.sv
// Register-file responder: runs a request's read/read/write phases in order on single-ported storage.
// Optional build macro RF_ZERO_REG_EN: register 0 is hardwired to zero and writes to it are dropped.
module rf_access_responder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_mask,
  input  logic [ADDR_W-1:0] read_address1,
  input  logic [ADDR_W-1:0] read_address2,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              resp_err,
  output logic              done
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic                rd2_pend_q, wr_pend_q;
  logic [ADDR_W-1:0]   ra1_q, ra2_q, wa_q;
  logic [DATA_W-1:0]   wd_q;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   rd1_d, rd2_d;
  logic                err_d, done_d, accept, wr_en, wr_hit;

  // Next state and next registered-output values.
  always_comb begin
    state_d = state_q;
    rd1_d   = read_data1;
    rd2_d   = read_data2;
    err_d   = resp_err;
    done_d  = 1'b0;
    accept  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          err_d  = (req_mask == 3'b000);
          if (req_mask[1])      state_d = RD1;
          else if (req_mask[2]) state_d = RD2;
          else if (req_mask[0]) state_d = WR;
          else                  state_d = RESP;
        end
      end
      RD1: begin
        rd1_d = regs[ra1_q];
        if (rd2_pend_q)     state_d = RD2;
        else if (wr_pend_q) state_d = WR;
        else                state_d = RESP;
      end
      RD2: begin
        rd2_d   = regs[ra2_q];
        state_d = wr_pend_q ? WR : RESP;
      end
      WR: begin
        wr_en   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          done_d  = 1'b1;
          rd1_d   = '0;
          rd2_d   = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RF_ZERO_REG_EN
  assign wr_hit = wr_en && (wa_q != '0);
`else
  assign wr_hit = wr_en;
`endif

  // State, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd2_pend_q <= 1'b0;
      wr_pend_q  <= 1'b0;
      ra1_q      <= '0;
      ra2_q      <= '0;
      wa_q       <= '0;
      wd_q       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      read_data1 <= '0;
      read_data2 <= '0;
      resp_err   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_ready  <= (state_d == IDLE);
      resp_valid <= (state_d == RESP);
      read_data1 <= rd1_d;
      read_data2 <= rd2_d;
      resp_err   <= err_d;
      done       <= done_d;
      if (accept) begin
        rd2_pend_q <= req_mask[2];
        wr_pend_q  <= req_mask[0];
        ra1_q      <= read_address1;
        ra2_q      <= read_address2;
        wa_q       <= write_address;
        wd_q       <= write_data;
      end
    end
  end

  // Register storage; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wa_q] <= wd_q;
    end
  end

endmodule

// File: tb/tb_rf_access_responder.sv
// Self-checking bench for rf_access_responder against an array-based register-file model.
module tb_rf_access_responder;

  logic        clk, rst_n;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, done;
  logic [2:0]  req_mask;
  logic [2:0]  read_address1, read_address2, write_address;
  logic [15:0] write_data, read_data1, read_data2;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] model [8];

  rf_access_responder #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mask(req_mask),
    .read_address1(read_address1), .read_address2(read_address2),
    .write_address(write_address), .write_data(write_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .read_data1(read_data1), .read_data2(read_data2),
    .resp_err(resp_err), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
  endtask

  // One complete request: accept, phases, optional response hold, accept of response.
  task automatic do_req(input logic [2:0] m, input int a1, input int a2, input int wa,
                        input logic [15:0] wd, input int hold);
    logic [15:0] e1, e2;
    int k, cnt, w;
    e1 = m[1] ? model[a1] : 16'h0;
    e2 = m[2] ? model[a2] : 16'h0;
    k  = int'(m[0]) + int'(m[1]) + int'(m[2]);
    w  = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_mask = m;
    read_address1 = 3'(a1); read_address2 = 3'(a2);
    write_address = 3'(wa); write_data = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (!resp_valid && cnt < 10) begin @(negedge clk); cnt++; end
    chk("latency", 32'(cnt), 32'(k));
    chk("rd1", 32'(read_data1), 32'(e1));
    chk("rd2", 32'(read_data2), 32'(e2));
    chk("err", 32'(resp_err), 32'(m == 3'b000));
    chk("req_ready_busy", 32'(req_ready), 32'd0);
`ifdef RF_ZERO_REG_EN
    if (m[0] && wa != 0) model[wa] = wd;
`else
    if (m[0]) model[wa] = wd;
`endif
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_mask = 3'($urandom);
      read_address1 = 3'($urandom); write_address = 3'($urandom);
      write_data = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rd1", 32'(read_data1), 32'(e1));
      chk("hold_rd2", 32'(read_data2), 32'(e2));
      chk("hold_err", 32'(resp_err), 32'(m == 3'b000));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("resp_clear", 32'({resp_valid, resp_err}), 32'd0);
    chk("data_clear", 32'({read_data1, read_data2}), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int ndone, last;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_mask = 3'b000;
    read_address1 = '0; read_address2 = '0; write_address = '0; write_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_outs", 32'({req_ready, resp_valid, resp_err, done}), 32'b1000);
    chk("rst_data", 32'({read_data1, read_data2}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(3'b001, 0, 0, 5, 16'hBEEF, 0);
    do_req(3'b010, 5, 0, 0, 16'h0, 0);
    do_req(3'b001, 0, 0, 3, 16'h00AA, 0);
    do_req(3'b111, 3, 5, 3, 16'h1234, 0);
    do_req(3'b010, 3, 0, 0, 16'h0, 1);
    do_req(3'b000, 0, 0, 0, 16'h0, 4);
    do_req(3'b110, 3, 5, 0, 16'h0, 0);
    do_req(3'b001, 0, 0, 0, 16'h7777, 0);
    do_req(3'b010, 0, 0, 0, 16'h0, 0);

    for (int i = 0; i < 40; i++)
      do_req(3'($urandom), int'($urandom_range(7)), int'($urandom_range(7)),
             int'($urandom_range(7)), 16'($urandom), int'($urandom_range(3)));

    // Back-to-back mask 110 with resp_ready held high.
    req_mask = 3'b110; read_address1 = 3'd3; read_address2 = 3'd6;
    req_valid = 1'b1; resp_ready = 1'b1;
    ndone = 0; last = -1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 16) req_valid = 1'b0;
      if (resp_valid) begin
        chk("b2b_rd1", 32'(read_data1), 32'(model[3]));
        chk("b2b_rd2", 32'(read_data2), 32'(model[6]));
      end
      if (done) begin
        ndone++;
        if (last >= 0) chk("b2b_period", 32'(c - last), 32'd4);
        last = c;
      end
    end
    resp_ready = 1'b0;
    chk("b2b_count", 32'(ndone), 32'd4);
    @(negedge clk);

    // Reset right after the accept edge, before the write commits.
    req_valid = 1'b1; req_mask = 3'b001; write_address = 3'd2; write_data = 16'h5555;
    @(posedge clk);
    #1 rst_n = 1'b0; req_valid = 1'b0;
    model_reset();
    #2;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    ndone = 0;
    repeat (3) begin @(negedge clk); if (done) ndone++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done) ndone++; end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    do_req(3'b110, 2, 5, 0, 16'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
